ins_check_stage: RTL and testbench
==================================

// Module: ins_check_stage
// PURPOSE
//  Parametrised instruction-check stage between instruction memory and the control unit (CU).
//  Classifies each fetched word as control (START/STOP/END), jump or normal.
//  Buffers normal/jump words in a small FIFO toward the CU and drives PC-select, CU-enable,
//  communication strobe and jump-redirect signals.
//  Valid/ready handshakes on both sides replace fixed-delay timing.
// PARAMETERS
//  BUS_WIDTH   32         instruction width (>=26)
//  SIG_WIDTH   19         control-signal field width, taken from ins[BUS_WIDTH-7 -: SIG_WIDTH]
//  CTRL_OPC    6'b111111  opcode ins[BUS_WIDTH-1 -: 6] marking a control word
//  JUMP_OPC    6'b101010  opcode marking a jump
//  JUMP_HOLD   3          cycles jump_out stays high (>=1)
//  FIFO_DEPTH  4          CU-side buffer depth (power of 2, >=2)
// PORTS
//  clock                     in   1          rising-edge clock
//  reset                     in   1          asynchronous, active-low
//  ins_in                    in   BUS_WIDTH  fetched instruction
//  ins_valid_in              in   1          ins_in valid
//  ins_ready_out             out  1          stage accepts ins_in this cycle
//  flush_in                  in   1          drop buffered words, cancel jump hold
//  ins_out                   out  BUS_WIDTH  FIFO head toward CU
//  ins_valid_out             out  1          ins_out valid
//  ins_ready_in              in   1          CU pops head
//  signal_out                out  SIG_WIDTH  latched control field of the last control word
//  communication_enable_out  out  1          1-cycle strobe: signal_out updated
//  pc_choice_out             out  1          1 = boot PC source, 0 = sequential PC
//  cu_enable_out             out  1          CU may execute
//  jump_out                  out  1          PC redirect request
//  drop_out                  out  1          1-cycle pulse: accepted word discarded
// BEHAVIOUR
//  Reset values: pc_choice_out=1; ins_ready_out=1; all other outputs 0; FIFO empty; state IDLE.
//  Accept = ins_valid_in & ins_ready_out.
//  ins_ready_out = !fifo_full & !jump_busy & !flush_in.
//  Control word: opc==CTRL_OPC. Sub-op = ins[BUS_WIDTH-7 -: 2]: 10 START, 11 STOP, 00 END, 01 reserved.
//  Control words never enter the FIFO.
//  For START, STOP and END: signal_out latched, and communication_enable_out pulses the cycle after accept.
//  Reserved sub-op: ignored, with no strobe and no state change.
//  FSM transitions (take effect the cycle after accept):
//   IDLE    --START--> RUN;  pc_choice_out->0.
//   RUN     --STOP---> STOPPED;  cu_enable_out->0; ins_valid_out masked 0; FIFO contents kept.
//   STOPPED --START--> RUN;  FIFO drains again.
//   any     --END----> ENDED;  FIFO flushed; cu_enable_out->0; pc_choice_out->1.
//   ENDED   --START--> RUN (restart).
//  Normal/jump word accepted in RUN: pushed; cu_enable_out->1 the next cycle.
//  Normal/jump word accepted in any other state: discarded; drop_out pulses.
//  Latency: a pushed word appears on ins_out 1 cycle after accept (no bypass).
//  A word stays on ins_out until ins_valid_out & ins_ready_in.
//  Jump accepted in RUN: jump_busy asserts immediately. jump_out is high on cycles +1..+JUMP_HOLD
//  after accept; jump_busy clears after the last jump_out cycle.
//  FIFO full: no push. Push and pop in the same cycle when not full: occupancy unchanged.
//  Pop when empty: no effect.
//  flush_in: FIFO emptied; jump_out and jump_busy cleared the next cycle; FSM state unchanged.
//  Any word presented during flush_in is not accepted.
//  Async reset mid-jump or mid-drain: immediate return to reset values.
// CONFIGURATION
//  ICHK_PERF_CNT_EN defined: adds outputs ins_count_out[15:0] and jump_count_out[15:0].
//   The counters count pushes and accepted jumps, saturate at 16'hFFFF, and clear on reset or END.
//  ICHK_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package ins_check_pkg: state_t enum {IDLE,RUN,STOPPED,ENDED}; subop_t enum; default opcode constants.
//  Sub-module ins_check_fifo: synchronous FIFO (FIFO_DEPTH, BUS_WIDTH) with push, pop, flush,
//  full and empty outputs.
//  Top level: classifier, FSM, jump-hold counter ($clog2(JUMP_HOLD+1) bits) and optional perf counters.
// TESTING
//  1. Reset; START word 0xFE80_0000+x -> next cycle: strobe=1, signal_out=ins[25:7], pc_choice_out=0.
//  2. In RUN, 5 normal words with ins_ready_in=0 -> 4 pushed, ins_ready_out=0 on the 5th.
//     ins_ready_in=1 -> FIFO drains in order.
//  3. Jump 0xA800_0001 in RUN -> jump_out high for exactly 3 cycles starting at accept+1;
//     ins_ready_out=0 until the hold ends.
//  4. STOP with 2 words buffered -> cu_enable_out=0, ins_valid_out=0; START -> both words emitted.
//  5. Normal word in IDLE -> drop_out pulse, FIFO stays empty.
//     END in RUN -> FIFO empty, pc_choice_out=1.
//  6. flush_in during jump hold with 3 words buffered -> jump_out=0 and FIFO empty next cycle.
//     Assert reset low mid-hold -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ins_check_pkg.sv
// Shared types and default opcodes for the instruction-check stage.
// Holds the FSM state enum, control sub-op enum and opcode constants.
package ins_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPED,
    ENDED
  } state_t;

  typedef enum logic [1:0] {
    SUB_END   = 2'b00,
    SUB_RSVD  = 2'b01,
    SUB_START = 2'b10,
    SUB_STOP  = 2'b11
  } subop_t;

  localparam logic [5:0] CTRL_OPC_DEF = 6'b111111;
  localparam logic [5:0] JUMP_OPC_DEF = 6'b101010;

endpackage

// File: rtl/ins_check_fifo.sv
// Synchronous FIFO buffering words toward the CU; flush empties it.
// Ports: clock, reset (async active-low), push/pop/flush, data in/out, full/empty.
module ins_check_fifo
  import ins_check_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_out  = cnt_q == (AW+1)'(DEPTH);
  assign empty_out = cnt_q == '0;
  assign data_out  = mem_q[rd_ptr_q];
  assign do_push   = push_in & ~full_out;
  assign do_pop    = pop_in & ~empty_out;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush_in) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/ins_check_stage.sv
// Instruction-check stage: classifies words, runs the START/STOP/END FSM,
// buffers normal/jump words toward the CU and holds jump redirects.
// Ports: clock/reset, ins_* handshakes, flush_in, signal/strobe, pc/cu/jump/drop.
// ICHK_PERF_CNT_EN adds ins_count_out and jump_count_out.
module ins_check_stage
  import ins_check_pkg::*;
#(
  parameter int         BUS_WIDTH  = 32,
  parameter int         SIG_WIDTH  = 19,
  parameter logic [5:0] CTRL_OPC   = CTRL_OPC_DEF,
  parameter logic [5:0] JUMP_OPC   = JUMP_OPC_DEF,
  parameter int         JUMP_HOLD  = 3,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] ins_in,
  input  logic                 ins_valid_in,
  output logic                 ins_ready_out,
  input  logic                 flush_in,
  output logic [BUS_WIDTH-1:0] ins_out,
  output logic                 ins_valid_out,
  input  logic                 ins_ready_in,
  output logic [SIG_WIDTH-1:0] signal_out,
  output logic                 communication_enable_out,
  output logic                 pc_choice_out,
  output logic                 cu_enable_out,
  output logic                 jump_out,
`ifdef ICHK_PERF_CNT_EN
  output logic [15:0]          ins_count_out,
  output logic [15:0]          jump_count_out,
`endif
  output logic                 drop_out
);

  localparam int HW = $clog2(JUMP_HOLD + 1);

  state_t         state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic           pc_q, pc_d;
  logic           cu_q, cu_d;
  logic           comm_q, comm_d;
  logic           drop_q, drop_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic [5:0]     opc;
  subop_t         subop;
  logic           is_ctrl, is_jump, run;
  logic           accept, acc_ctrl, acc_run, acc_drop;
  logic           jump_busy, full, empty;
  logic           push, pop, fifo_flush;

  assign opc       = ins_in[BUS_WIDTH-1 -: 6];
  assign subop     = subop_t'(ins_in[BUS_WIDTH-7 -: 2]);
  assign is_ctrl   = opc == CTRL_OPC;
  assign is_jump   = opc == JUMP_OPC;
  assign run       = state_q == RUN;
  assign jump_busy = hold_q != '0;

  assign ins_ready_out = ~full & ~jump_busy & ~flush_in;
  assign accept        = ins_valid_in & ins_ready_out;
  assign acc_ctrl      = accept & is_ctrl;
  assign acc_run       = accept & ~is_ctrl & run;
  assign acc_drop      = accept & ~is_ctrl & ~run;

  // Buffered words are held back while STOPPED; other non-RUN
  // states always have an empty FIFO.
  assign ins_valid_out = ~empty & run;
  assign push          = acc_run;
  assign pop           = ins_valid_out & ins_ready_in;
  assign fifo_flush    = flush_in | (acc_ctrl & (subop == SUB_END));

  ins_check_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUS_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_in   (push),
    .pop_in    (pop),
    .flush_in  (fifo_flush),
    .data_in   (ins_in),
    .data_out  (ins_out),
    .full_out  (full),
    .empty_out (empty)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    pc_d    = pc_q;
    cu_d    = cu_q;
    comm_d  = 1'b0;
    drop_d  = 1'b0;
    hold_d  = jump_busy ? hold_q - HW'(1) : hold_q;
    unique case (1'b1)
      acc_ctrl: begin
        unique case (subop)
          SUB_START: begin
            state_d = RUN;
            pc_d    = 1'b0;
            // Resume CU when STOP left words behind.
            if (!empty) cu_d = 1'b1;
          end
          SUB_STOP: begin
            if (run) begin
              state_d = STOPPED;
              cu_d    = 1'b0;
            end
          end
          SUB_END: begin
            state_d = ENDED;
            cu_d    = 1'b0;
            pc_d    = 1'b1;
          end
          default: ;
        endcase
        if (subop != SUB_RSVD) begin
          sig_d  = ins_in[BUS_WIDTH-7 -: SIG_WIDTH];
          comm_d = 1'b1;
        end
      end
      acc_run: begin
        cu_d = 1'b1;
        if (is_jump) hold_d = HW'(JUMP_HOLD);
      end
      acc_drop: drop_d = 1'b1;
      default: ;
    endcase
    if (flush_in) hold_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sig_q   <= '0;
      pc_q    <= 1'b1;
      cu_q    <= 1'b0;
      comm_q  <= 1'b0;
      drop_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      pc_q    <= pc_d;
      cu_q    <= cu_d;
      comm_q  <= comm_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
    end
  end

  assign signal_out               = sig_q;
  assign communication_enable_out = comm_q;
  assign pc_choice_out            = pc_q;
  assign cu_enable_out            = cu_q;
  assign jump_out                 = jump_busy;
  assign drop_out                 = drop_q;

`ifdef ICHK_PERF_CNT_EN
  logic [15:0] ins_cnt_q, ins_cnt_d;
  logic [15:0] jmp_cnt_q, jmp_cnt_d;
  logic        cnt_clr;

  assign cnt_clr = acc_ctrl & (subop == SUB_END);

  always_comb begin
    ins_cnt_d = ins_cnt_q;
    jmp_cnt_d = jmp_cnt_q;
    if (cnt_clr) begin
      ins_cnt_d = '0;
      jmp_cnt_d = '0;
    end else begin
      if (push && ins_cnt_q != 16'hFFFF)
        ins_cnt_d = ins_cnt_q + 16'd1;
      if (acc_run && is_jump && jmp_cnt_q != 16'hFFFF)
        jmp_cnt_d = jmp_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ins_cnt_q <= '0;
      jmp_cnt_q <= '0;
    end else begin
      ins_cnt_q <= ins_cnt_d;
      jmp_cnt_q <= jmp_cnt_d;
    end
  end

  assign ins_count_out  = ins_cnt_q;
  assign jump_count_out = jmp_cnt_q;
`endif

endmodule

// File: tb/tb_ins_check_stage.sv
// Directed bench for ins_check_stage: vector table plus
// hand sequences for flush, mid-hold reset and ready gating.
module tb_ins_check_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ins_in = '0;
  logic        ins_valid_in = 1'b0;
  logic        ins_ready_out;
  logic        flush_in = 1'b0;
  logic [31:0] ins_out;
  logic        ins_valid_out;
  logic        ins_ready_in = 1'b0;
  logic [18:0] signal_out;
  logic        communication_enable_out;
  logic        pc_choice_out;
  logic        cu_enable_out;
  logic        jump_out;
  logic        drop_out;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ins_check_stage dut (
    .clock                    (clock),
    .reset                    (reset),
    .ins_in                   (ins_in),
    .ins_valid_in             (ins_valid_in),
    .ins_ready_out            (ins_ready_out),
    .flush_in                 (flush_in),
    .ins_out                  (ins_out),
    .ins_valid_out            (ins_valid_out),
    .ins_ready_in             (ins_ready_in),
    .signal_out               (signal_out),
    .communication_enable_out (communication_enable_out),
    .pc_choice_out            (pc_choice_out),
    .cu_enable_out            (cu_enable_out),
    .jump_out                 (jump_out),
    .drop_out                 (drop_out)
  );

  typedef struct {
    logic [31:0] ins;
    logic        vld, rdy, fl;
    logic        e_rdy, e_vld;
    logic [31:0] e_ins;
    logic        e_comm;
    logic [18:0] e_sig;
    logic        e_pc, e_cu, e_jmp, e_drop;
  } vec_t;

  vec_t v[27];

  function automatic vec_t mk(
    input int w, input int vl, input int rd, input int fl,
    input int er, input int ev, input int ei, input int ec,
    input int es, input int ep, input int eu, input int ej,
    input int ed);
    vec_t r;
    r.ins = w;      r.vld = vl[0];  r.rdy = rd[0];  r.fl = fl[0];
    r.e_rdy = er[0]; r.e_vld = ev[0]; r.e_ins = ei;
    r.e_comm = ec[0]; r.e_sig = es[18:0]; r.e_pc = ep[0];
    r.e_cu = eu[0]; r.e_jmp = ej[0]; r.e_drop = ed[0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] w, input logic vl,
                     input logic rd, input logic fl);
    @(negedge clock);
    ins_in = w; ins_valid_in = vl; ins_ready_in = rd; flush_in = fl;
    @(posedge clock);
    #1;
    ins_in = '0; ins_valid_in = 1'b0; flush_in = 1'b0;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rdy"},  32'(ins_ready_out), 32'd1);
    chk({tag, " vld"},  32'(ins_valid_out), 32'd0);
    chk({tag, " comm"}, 32'(communication_enable_out), 32'd0);
    chk({tag, " sig"},  32'(signal_out), 32'd0);
    chk({tag, " pc"},   32'(pc_choice_out), 32'd1);
    chk({tag, " cu"},   32'(cu_enable_out), 32'd0);
    chk({tag, " jmp"},  32'(jump_out), 32'd0);
    chk({tag, " drop"}, 32'(drop_out), 32'd0);
  endtask

  initial begin
    //         ins        vl rd fl  rdy vld ins     comm sig     pc cu jmp drop
    v[0]  = mk(32'h99,       1,0,0, 1,0,0,           0,'h0,     1,0,0,1);
    v[1]  = mk(32'hFE800080, 1,0,0, 1,0,0,           1,'h50001, 0,0,0,0);
    v[2]  = mk(32'h11,       1,0,0, 1,1,'h11,        0,'h50001, 0,1,0,0);
    v[3]  = mk(32'h22,       1,0,0, 1,1,'h11,        0,'h50001, 0,1,0,0);
    v[4]  = mk(32'h33,       1,0,0, 1,1,'h11,        0,'h50001, 0,1,0,0);
    v[5]  = mk(32'h44,       1,0,0, 0,1,'h11,        0,'h50001, 0,1,0,0);
    v[6]  = mk(32'h55,       1,0,0, 0,1,'h11,        0,'h50001, 0,1,0,0);
    v[7]  = mk(32'h0,        0,1,0, 1,1,'h22,        0,'h50001, 0,1,0,0);
    v[8]  = mk(32'h0,        0,1,0, 1,1,'h33,        0,'h50001, 0,1,0,0);
    v[9]  = mk(32'h0,        0,1,0, 1,1,'h44,        0,'h50001, 0,1,0,0);
    v[10] = mk(32'h0,        0,1,0, 1,0,0,           0,'h50001, 0,1,0,0);
    v[11] = mk(32'hA8000001, 1,1,0, 0,1,'hA8000001,  0,'h50001, 0,1,1,0);
    v[12] = mk(32'h0,        0,1,0, 0,0,0,           0,'h50001, 0,1,1,0);
    v[13] = mk(32'h0,        0,1,0, 0,0,0,           0,'h50001, 0,1,1,0);
    v[14] = mk(32'h0,        0,1,0, 1,0,0,           0,'h50001, 0,1,0,0);
    v[15] = mk(32'h66,       1,0,0, 1,1,'h66,        0,'h50001, 0,1,0,0);
    v[16] = mk(32'h77,       1,0,0, 1,1,'h66,        0,'h50001, 0,1,0,0);
    v[17] = mk(32'hFF000000, 1,0,0, 1,0,0,           1,'h60000, 0,0,0,0);
    v[18] = mk(32'h0,        0,1,0, 1,0,0,           0,'h60000, 0,0,0,0);
    v[19] = mk(32'hFE800000, 1,1,0, 1,1,'h66,        1,'h50000, 0,1,0,0);
    v[20] = mk(32'h0,        0,1,0, 1,1,'h77,        0,'h50000, 0,1,0,0);
    v[21] = mk(32'h0,        0,1,0, 1,0,0,           0,'h50000, 0,1,0,0);
    v[22] = mk(32'hFD000000, 1,1,0, 1,0,0,           0,'h50000, 0,1,0,0);
    v[23] = mk(32'h88,       1,0,0, 1,1,'h88,        0,'h50000, 0,1,0,0);
    v[24] = mk(32'hFC000000, 1,0,0, 1,0,0,           1,'h0,     1,0,0,0);
    v[25] = mk(32'h99,       1,0,0, 1,0,0,           0,'h0,     1,0,0,1);
    v[26] = mk(32'h0,        0,0,0, 1,0,0,           0,'h0,     1,0,0,0);

    #12;
    chk_reset_vals("rst0");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 27; i++) begin
      cyc(v[i].ins, v[i].vld, v[i].rdy, v[i].fl);
      chk($sformatf("r%0d rdy", i), 32'(ins_ready_out), 32'(v[i].e_rdy));
      chk($sformatf("r%0d vld", i), 32'(ins_valid_out), 32'(v[i].e_vld));
      if (v[i].e_vld)
        chk($sformatf("r%0d ins", i), ins_out, v[i].e_ins);
      chk($sformatf("r%0d comm", i),
          32'(communication_enable_out), 32'(v[i].e_comm));
      chk($sformatf("r%0d sig", i), 32'(signal_out), 32'(v[i].e_sig));
      chk($sformatf("r%0d pc", i), 32'(pc_choice_out), 32'(v[i].e_pc));
      chk($sformatf("r%0d cu", i), 32'(cu_enable_out), 32'(v[i].e_cu));
      chk($sformatf("r%0d jmp", i), 32'(jump_out), 32'(v[i].e_jmp));
      chk($sformatf("r%0d drop", i), 32'(drop_out), 32'(v[i].e_drop));
    end

    // flush_in alone must block acceptance
    @(negedge clock);
    flush_in = 1'b1;
    ins_valid_in = 1'b1;
    ins_in = 32'h5A;
    #1;
    chk("flush gates ready", 32'(ins_ready_out), 32'd0);
    @(posedge clock);
    #1;
    flush_in = 1'b0; ins_valid_in = 1'b0; ins_in = '0;
    #1;
    chk("flush no drop", 32'(drop_out), 32'd0);

    // restart from ENDED, buffer 3 words incl. jump, then flush
    cyc(32'hFE800000, 1'b1, 1'b0, 1'b0);
    chk("restart pc", 32'(pc_choice_out), 32'd0);
    cyc(32'hA1, 1'b1, 1'b0, 1'b0);
    cyc(32'hA2, 1'b1, 1'b0, 1'b0);
    cyc(32'hA8000001, 1'b1, 1'b0, 1'b0);
    chk("hold jmp", 32'(jump_out), 32'd1);
    chk("hold rdy", 32'(ins_ready_out), 32'd0);
    chk("hold head", ins_out, 32'hA1);
    cyc(32'h0, 1'b0, 1'b0, 1'b1);
    chk("flush jmp", 32'(jump_out), 32'd0);
    chk("flush vld", 32'(ins_valid_out), 32'd0);
    chk("flush rdy", 32'(ins_ready_out), 32'd1);

    // async reset in the middle of a jump hold
    cyc(32'hB1, 1'b1, 1'b0, 1'b0);
    chk("pre-rst head", ins_out, 32'hB1);
    cyc(32'hA8000002, 1'b1, 1'b0, 1'b0);
    chk("pre-rst jmp", 32'(jump_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
